rs_issue_unit: RTL
==================

// Module: rs_issue_unit
// PURPOSE
//  Transmit side of the reservation-station issue interface. Takes decoded instructions (valid/ready) into a
//  one-entry pending register, resolves both operands (regfile, ROB, ALU/LSB broadcast), allocates a ROB entry,
//  renames rd, and drives one registered issue_* beat per instruction into the RS. Sits between decoder and RS/ROB.
// PARAMETERS
//  XLEN   32  data width
//  ROB_W  6   ROB index width (dep tags, rob_index)
//  OPC_W  6   internal opcode width; opcode 0 = bubble, never issued
// PORTS
//  clk            in   1      clock; all state on posedge
//  rst_n          in   1      reset, asynchronous, active-low
//  rdy            in   1      global enable; rdy=0 freezes all state, fire forced 0
//  flush          in   1      mispredict flush
//  dec_valid/dec_ready in/out 1  decoder handshake; transfer when both high
//  dec_opcode     in   OPC_W  ; dec_rd/dec_rs1/dec_rs2 in 5 ; dec_use_rs1/dec_use_rs2 in 1
//  dec_imm/dec_pc in   XLEN
//  rf_rs1/rf_rs2  out  5      regfile query (comb, from pending reg)
//  rf_val1/2      in   XLEN ; rf_busy1/2 in 1 ; rf_tag1/2 in ROB_W   regfile answers (comb)
//  rob_q1/rob_q2  out  ROB_W  ROB query = rf_tag1/2 ; rob_rdy1/2 in 1 ; rob_val1/2 in XLEN
//  rob_full       in   1 ;    rob_tail in ROB_W   next free ROB index
//  rob_alloc      out  1      comb pulse = fire; ROB advances tail at edge
//  ren_valid      out  1      comb = fire && rd!=0 ; ren_rd out 5 ; ren_tag out ROB_W (= rob_tail)
//  alu_valid,alu_is_load in 1 ; alu_rob_index_out in ROB_W ; alu_res in XLEN   ALU broadcast
//  lsb_valid      in   1 ;    lsb_rs_rob_index_out in ROB_W ; lsb_rs_res in XLEN   LSB broadcast
//  rs_full        in   1      RS has <=1 free slot
//  issue_valid    out  1      registered one-cycle beat to RS
//  issue_opcode   out  OPC_W ; issue_val1/2 out XLEN ; issue_dep1/2 out ROB_W ; issue_has_dep1/2 out 1
//  issue_rob_index out ROB_W ; issue_imm/issue_pc out XLEN
// BEHAVIOUR
//  - Reset: pend_valid=0, every issue_* output 0, comb outputs 0.
//  - fire = rdy & pend_valid & ~rs_full & ~rob_full & ~flush. dec_ready = rdy & ~flush & (~pend_valid | fire).
//  - Pending reg loads on dec_valid&dec_ready; cleared on fire without a new load; holds otherwise.
//  - On fire (edge): issue_valid<=1, fields from pend, issue_rob_index<=rob_tail. No fire: issue_valid<=0,
//    issue_opcode<=0, other fields hold. Latency: decode accept -> issue_valid = 2 cycles min; 1/cycle throughput.
//  - Operand resolution per side, priority: ~use_rsX -> val 0, has_dep 0; ~rf_busyX -> rf_valX;
//    rob_rdyX -> rob_valX; alu_valid & ~alu_is_load & tag match -> alu_res; lsb_valid & tag match -> lsb_rs_res;
//    else has_dep=1, dep=rf_tagX, val=0. rs1/rs2 = x0 -> val 0, has_dep 0 (regfile never busy for x0).
//  - Operand self-reference (rsX==rd) uses old mapping; rename lands at same edge.
//  - Broadcast in the issue_valid cycle is caught by RS-side bypass; this unit need not replay it.
//  - rs_full 1-entry margin covers registered issue lag; never fire when rs_full=1.
//  - flush: pend_valid<=0, issue_valid<=0, issue_opcode<=0, no alloc/rename that cycle; dec_ready=0.
//  - Stall (rs_full or rob_full): pend holds, operands re-resolved every cycle (picks up late broadcasts).
//  - Async reset mid-stall/mid-issue: outputs go to 0 immediately, no partial ROB/rename pulse after release.
// STRUCTURE
//  - Shared package/config.vh: OPC_W, ROB_W, OPC_NOP=0, bubble encoding.
//  - Sub-module operand_resolve (combinational priority mux), instantiated twice. Rest is top-level regs.
// TESTING
//  1 Reset: rst_n=0 during issue_valid=1 -> all issue_* 0 that instant; dec_ready=0 until rst_n=1.
//  2 addi x1,x2,5, rf_busy2=0, rf_val2=7, rob_tail=3 -> 2 cyc later issue_valid=1, val1=7, has_dep1=0,
//    imm=5, rob_index=3; ren_valid=1 rd=1 tag=3 in fire cycle.
//  3 Back-to-back add x3,x1,x1 after test 2, regfile tag1=3 -> has_dep1=has_dep2=1, dep=3, rob_index=4.
//  4 Pending dep tag 5 stalled by rs_full; alu_valid=1 idx=5 res=0x99 (not load) -> after rs_full=0 issue
//    has_dep=0 val=0x99; same with alu_is_load=1 -> has_dep stays 1.
//  5 rob_full=1 for 3 cycles -> no rob_alloc, dec_ready=0, single issue_valid beat after release.
//  6 flush with pend_valid=1 and issue_valid=1 -> next cycle issue_valid=0, pend empty, no rob_alloc/ren_valid.

Source files
------------

// File: rtl/rs_issue_unit_pkg.sv
// Shared constants and types for the reservation-station issue unit.
//  - Default data / ROB tag / opcode widths, architectural register index width.
//  - Bubble opcode encoding (never issued).
//  - Operand source selector used inside the operand resolver.
package rs_issue_unit_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned ROB_W_DEF = 6;
    localparam int unsigned OPC_W_DEF = 6;
    localparam int unsigned REG_W     = 5;

    // Opcode 0 is a bubble: accepted from the decoder but never issued.
    localparam int unsigned OPC_NOP = 0;

    typedef enum logic [2:0] {
        SrcZero,  // operand unused or x0
        SrcRf,    // committed value from the regfile
        SrcRob,   // producer finished, value parked in the ROB
        SrcAlu,   // ALU result broadcast this cycle
        SrcLsb,   // LSB result broadcast this cycle
        SrcDep    // still outstanding; RS must wait on the tag
    } opnd_src_e;

endpackage

// File: rtl/rs_issue_unit_operand_resolve.sv
// Combinational operand resolver for one source operand.
//  Inputs : use flag and register index, regfile answer (val/busy/tag), ROB answer (rdy/val),
//           ALU and LSB result broadcasts.
//  Outputs: val (resolved value or 0), has_dep (operand still outstanding), dep (tag when has_dep).
module rs_issue_unit_operand_resolve
    import rs_issue_unit_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned ROB_W = ROB_W_DEF
) (
    input  logic             use_rs,
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  rf_val,
    input  logic             rf_busy,
    input  logic [ROB_W-1:0] rf_tag,
    input  logic             rob_rdy,
    input  logic [XLEN-1:0]  rob_val,
    input  logic             alu_valid,
    input  logic             alu_is_load,
    input  logic [ROB_W-1:0] alu_rob_index,
    input  logic [XLEN-1:0]  alu_res,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_rob_index,
    input  logic [XLEN-1:0]  lsb_res,
    output logic [XLEN-1:0]  val,
    output logic [ROB_W-1:0] dep,
    output logic             has_dep
);

    opnd_src_e src;

    // Priority chain; x0 is forced to zero regardless of what the regfile reports.
    // ALU load results are not final (LSB delivers them), so they are ignored here.
    always_comb begin
        if (!use_rs || (rs == '0)) begin
            src = SrcZero;
        end else if (!rf_busy) begin
            src = SrcRf;
        end else if (rob_rdy) begin
            src = SrcRob;
        end else if (alu_valid && !alu_is_load && (alu_rob_index == rf_tag)) begin
            src = SrcAlu;
        end else if (lsb_valid && (lsb_rob_index == rf_tag)) begin
            src = SrcLsb;
        end else begin
            src = SrcDep;
        end
    end

    always_comb begin
        val     = '0;
        dep     = '0;
        has_dep = 1'b0;
        unique case (src)
            SrcRf:  val = rf_val;
            SrcRob: val = rob_val;
            SrcAlu: val = alu_res;
            SrcLsb: val = lsb_res;
            SrcDep: begin
                dep     = rf_tag;
                has_dep = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rs_issue_unit.sv
// Issue stage between decoder and reservation station / ROB.
//  - Decoder side : dec_valid/dec_ready handshake into a one-entry pending register.
//  - Regfile/ROB  : combinational operand queries driven from the pending register.
//  - ROB/rename   : rob_alloc and ren_* pulses in the cycle an instruction fires.
//  - Broadcasts   : ALU/LSB results resolve outstanding operands while pending.
//  - RS side      : registered one-cycle issue_* beat per instruction.
module rs_issue_unit
    import rs_issue_unit_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned ROB_W = ROB_W_DEF,
    parameter int unsigned OPC_W = OPC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    // decoder
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [OPC_W-1:0] dec_opcode,
    input  logic [REG_W-1:0] dec_rd,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic [XLEN-1:0]  dec_imm,
    input  logic [XLEN-1:0]  dec_pc,
    // regfile query
    output logic [REG_W-1:0] rf_rs1,
    output logic [REG_W-1:0] rf_rs2,
    input  logic [XLEN-1:0]  rf_val1,
    input  logic [XLEN-1:0]  rf_val2,
    input  logic             rf_busy1,
    input  logic             rf_busy2,
    input  logic [ROB_W-1:0] rf_tag1,
    input  logic [ROB_W-1:0] rf_tag2,
    // ROB query and allocation
    output logic [ROB_W-1:0] rob_q1,
    output logic [ROB_W-1:0] rob_q2,
    input  logic             rob_rdy1,
    input  logic             rob_rdy2,
    input  logic [XLEN-1:0]  rob_val1,
    input  logic [XLEN-1:0]  rob_val2,
    input  logic             rob_full,
    input  logic [ROB_W-1:0] rob_tail,
    output logic             rob_alloc,
    // rename
    output logic             ren_valid,
    output logic [REG_W-1:0] ren_rd,
    output logic [ROB_W-1:0] ren_tag,
    // result broadcasts
    input  logic             alu_valid,
    input  logic             alu_is_load,
    input  logic [ROB_W-1:0] alu_rob_index_out,
    input  logic [XLEN-1:0]  alu_res,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_rs_rob_index_out,
    input  logic [XLEN-1:0]  lsb_rs_res,
    // reservation station
    input  logic             rs_full,
    output logic             issue_valid,
    output logic [OPC_W-1:0] issue_opcode,
    output logic [XLEN-1:0]  issue_val1,
    output logic [XLEN-1:0]  issue_val2,
    output logic [ROB_W-1:0] issue_dep1,
    output logic [ROB_W-1:0] issue_dep2,
    output logic             issue_has_dep1,
    output logic             issue_has_dep2,
    output logic [ROB_W-1:0] issue_rob_index,
    output logic [XLEN-1:0]  issue_imm,
    output logic [XLEN-1:0]  issue_pc
);

    logic             pend_valid_d,  pend_valid_q;
    logic [OPC_W-1:0] pend_opcode_d, pend_opcode_q;
    logic [REG_W-1:0] pend_rd_d,     pend_rd_q;
    logic [REG_W-1:0] pend_rs1_d,    pend_rs1_q;
    logic [REG_W-1:0] pend_rs2_d,    pend_rs2_q;
    logic             pend_use1_d,   pend_use1_q;
    logic             pend_use2_d,   pend_use2_q;
    logic [XLEN-1:0]  pend_imm_d,    pend_imm_q;
    logic [XLEN-1:0]  pend_pc_d,     pend_pc_q;

    logic             issue_valid_d,     issue_valid_q;
    logic [OPC_W-1:0] issue_opcode_d,    issue_opcode_q;
    logic [XLEN-1:0]  issue_val1_d,      issue_val1_q;
    logic [XLEN-1:0]  issue_val2_d,      issue_val2_q;
    logic [ROB_W-1:0] issue_dep1_d,      issue_dep1_q;
    logic [ROB_W-1:0] issue_dep2_d,      issue_dep2_q;
    logic             issue_has_dep1_d,  issue_has_dep1_q;
    logic             issue_has_dep2_d,  issue_has_dep2_q;
    logic [ROB_W-1:0] issue_rob_index_d, issue_rob_index_q;
    logic [XLEN-1:0]  issue_imm_d,       issue_imm_q;
    logic [XLEN-1:0]  issue_pc_d,        issue_pc_q;

    logic             fire;
    logic             accept;
    logic [XLEN-1:0]  res_val1, res_val2;
    logic [ROB_W-1:0] res_dep1, res_dep2;
    logic             res_has_dep1, res_has_dep2;

    rs_issue_unit_operand_resolve #(
        .XLEN  (XLEN),
        .ROB_W (ROB_W)
    ) u_resolve1 (
        .use_rs        (pend_use1_q),
        .rs            (pend_rs1_q),
        .rf_val        (rf_val1),
        .rf_busy       (rf_busy1),
        .rf_tag        (rf_tag1),
        .rob_rdy       (rob_rdy1),
        .rob_val       (rob_val1),
        .alu_valid     (alu_valid),
        .alu_is_load   (alu_is_load),
        .alu_rob_index (alu_rob_index_out),
        .alu_res       (alu_res),
        .lsb_valid     (lsb_valid),
        .lsb_rob_index (lsb_rs_rob_index_out),
        .lsb_res       (lsb_rs_res),
        .val           (res_val1),
        .dep           (res_dep1),
        .has_dep       (res_has_dep1)
    );

    rs_issue_unit_operand_resolve #(
        .XLEN  (XLEN),
        .ROB_W (ROB_W)
    ) u_resolve2 (
        .use_rs        (pend_use2_q),
        .rs            (pend_rs2_q),
        .rf_val        (rf_val2),
        .rf_busy       (rf_busy2),
        .rf_tag        (rf_tag2),
        .rob_rdy       (rob_rdy2),
        .rob_val       (rob_val2),
        .alu_valid     (alu_valid),
        .alu_is_load   (alu_is_load),
        .alu_rob_index (alu_rob_index_out),
        .alu_res       (alu_res),
        .lsb_valid     (lsb_valid),
        .lsb_rob_index (lsb_rs_rob_index_out),
        .lsb_res       (lsb_rs_res),
        .val           (res_val2),
        .dep           (res_dep2),
        .has_dep       (res_has_dep2)
    );

    // Handshake and side-band pulses. rst_n gates the pulses so nothing leaks out while in reset.
    always_comb begin
        fire      = rst_n & rdy & pend_valid_q & ~rs_full & ~rob_full & ~flush;
        dec_ready = rst_n & rdy & ~flush & (~pend_valid_q | fire);
        accept    = dec_valid & dec_ready;
        rob_alloc = fire;
        ren_valid = fire & (pend_rd_q != '0);
        ren_rd    = pend_rd_q;
        ren_tag   = rob_tail;
        rf_rs1    = pend_rs1_q;
        rf_rs2    = pend_rs2_q;
        rob_q1    = rf_tag1;
        rob_q2    = rf_tag2;
    end

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_opcode_d = pend_opcode_q;
        pend_rd_d     = pend_rd_q;
        pend_rs1_d    = pend_rs1_q;
        pend_rs2_d    = pend_rs2_q;
        pend_use1_d   = pend_use1_q;
        pend_use2_d   = pend_use2_q;
        pend_imm_d    = pend_imm_q;
        pend_pc_d     = pend_pc_q;
        if (rdy) begin
            if (flush) begin
                pend_valid_d = 1'b0;
            end else if (accept) begin
                // Bubbles complete the handshake but leave the slot empty.
                pend_valid_d  = (dec_opcode != OPC_W'(OPC_NOP));
                pend_opcode_d = dec_opcode;
                pend_rd_d     = dec_rd;
                pend_rs1_d    = dec_rs1;
                pend_rs2_d    = dec_rs2;
                pend_use1_d   = dec_use_rs1;
                pend_use2_d   = dec_use_rs2;
                pend_imm_d    = dec_imm;
                pend_pc_d     = dec_pc;
            end else if (fire) begin
                pend_valid_d = 1'b0;
            end
        end
    end

    // Payload fields hold between beats; only valid and opcode are cleared on idle cycles.
    always_comb begin
        issue_valid_d     = issue_valid_q;
        issue_opcode_d    = issue_opcode_q;
        issue_val1_d      = issue_val1_q;
        issue_val2_d      = issue_val2_q;
        issue_dep1_d      = issue_dep1_q;
        issue_dep2_d      = issue_dep2_q;
        issue_has_dep1_d  = issue_has_dep1_q;
        issue_has_dep2_d  = issue_has_dep2_q;
        issue_rob_index_d = issue_rob_index_q;
        issue_imm_d       = issue_imm_q;
        issue_pc_d        = issue_pc_q;
        if (rdy) begin
            if (fire) begin
                issue_valid_d     = 1'b1;
                issue_opcode_d    = pend_opcode_q;
                issue_val1_d      = res_val1;
                issue_val2_d      = res_val2;
                issue_dep1_d      = res_dep1;
                issue_dep2_d      = res_dep2;
                issue_has_dep1_d  = res_has_dep1;
                issue_has_dep2_d  = res_has_dep2;
                issue_rob_index_d = rob_tail;
                issue_imm_d       = pend_imm_q;
                issue_pc_d        = pend_pc_q;
            end else begin
                issue_valid_d  = 1'b0;
                issue_opcode_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q      <= 1'b0;
            pend_opcode_q     <= '0;
            pend_rd_q         <= '0;
            pend_rs1_q        <= '0;
            pend_rs2_q        <= '0;
            pend_use1_q       <= 1'b0;
            pend_use2_q       <= 1'b0;
            pend_imm_q        <= '0;
            pend_pc_q         <= '0;
            issue_valid_q     <= 1'b0;
            issue_opcode_q    <= '0;
            issue_val1_q      <= '0;
            issue_val2_q      <= '0;
            issue_dep1_q      <= '0;
            issue_dep2_q      <= '0;
            issue_has_dep1_q  <= 1'b0;
            issue_has_dep2_q  <= 1'b0;
            issue_rob_index_q <= '0;
            issue_imm_q       <= '0;
            issue_pc_q        <= '0;
        end else begin
            pend_valid_q      <= pend_valid_d;
            pend_opcode_q     <= pend_opcode_d;
            pend_rd_q         <= pend_rd_d;
            pend_rs1_q        <= pend_rs1_d;
            pend_rs2_q        <= pend_rs2_d;
            pend_use1_q       <= pend_use1_d;
            pend_use2_q       <= pend_use2_d;
            pend_imm_q        <= pend_imm_d;
            pend_pc_q         <= pend_pc_d;
            issue_valid_q     <= issue_valid_d;
            issue_opcode_q    <= issue_opcode_d;
            issue_val1_q      <= issue_val1_d;
            issue_val2_q      <= issue_val2_d;
            issue_dep1_q      <= issue_dep1_d;
            issue_dep2_q      <= issue_dep2_d;
            issue_has_dep1_q  <= issue_has_dep1_d;
            issue_has_dep2_q  <= issue_has_dep2_d;
            issue_rob_index_q <= issue_rob_index_d;
            issue_imm_q       <= issue_imm_d;
            issue_pc_q        <= issue_pc_d;
        end
    end

    assign issue_valid     = issue_valid_q;
    assign issue_opcode    = issue_opcode_q;
    assign issue_val1      = issue_val1_q;
    assign issue_val2      = issue_val2_q;
    assign issue_dep1      = issue_dep1_q;
    assign issue_dep2      = issue_dep2_q;
    assign issue_has_dep1  = issue_has_dep1_q;
    assign issue_has_dep2  = issue_has_dep2_q;
    assign issue_rob_index = issue_rob_index_q;
    assign issue_imm       = issue_imm_q;
    assign issue_pc        = issue_pc_q;

endmodule
